// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants, pixel colour type and the bounce palette.
package vga_pkg;
  localparam int CNT_W     = 10;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

  typedef logic [7:0] rgb332_t;

  function automatic rgb332_t palette_color(input logic [2:0] idx);
    case (idx)
      3'd0:    palette_color = 8'hE0;
      3'd1:    palette_color = 8'hFC;
      3'd2:    palette_color = 8'h1C;
      3'd3:    palette_color = 8'h1F;
      3'd4:    palette_color = 8'h03;
      3'd5:    palette_color = 8'hE3;
      3'd6:    palette_color = 8'hFF;
      default: palette_color = 8'h92;
    endcase
  endfunction
endpackage

// File: rtl/bounce_axis.sv
// One axis of box motion: steps SPEED per frame, clamps at 0 / LIM and reverses.
import vga_pkg::*;

module bounce_axis #(
  parameter int LIM   = 608,
  parameter int SPEED = 2,
  parameter int INIT  = 100
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W:0]   pos,
  output logic             bounce
);
  logic [CNT_W:0] pos_q, pos_d;
  logic           dir_q, dir_d;  // 1 = increasing

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    bounce = 1'b0;
    if (step) begin
      if (dir_q) begin
        if (pos_q + (CNT_W+1)'(SPEED) >= (CNT_W+1)'(LIM)) begin
          pos_d  = (CNT_W+1)'(LIM);
          dir_d  = 1'b0;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q + (CNT_W+1)'(SPEED);
        end
      end else begin
        if (pos_q <= (CNT_W+1)'(SPEED)) begin
          pos_d  = '0;
          dir_d  = 1'b1;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q - (CNT_W+1)'(SPEED);
        end
      end
    end
  end

  always_ff @(posedge vgaclk) begin
    if (!rst) begin
      pos_q <= (CNT_W+1)'(INIT);
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
endmodule

// File: rtl/box_pixel_gen.sv
// Bouncing-box pixel source for the vga beam counters; output pixel lags the
// counters by one clock, and the box moves once per frame during vertical blanking.
import vga_pkg::*;

module box_pixel_gen #(
  parameter int      BOX_W    = 32,
  parameter int      BOX_H    = 32,
  parameter int      SPEED    = 2,
  parameter int      INIT_X   = 100,
  parameter int      INIT_Y   = 60,
  parameter rgb332_t BG_COLOR = 8'h02
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic [CNT_W-1:0] hc_in,
  input  logic [CNT_W-1:0] vc_in,
  input  logic             pause,
  output logic [2:0]       input_red,
  output logic [2:0]       input_green,
  output logic [1:0]       input_blue,
  output logic             frame_tick
);
  logic [CNT_W:0] pos_x, pos_y;
  logic           bounce_x, bounce_y;
  logic           step;
  logic           frame_tick_q, frame_tick_d;
  logic [2:0]     color_idx_q, color_idx_d;
  rgb332_t        rgb_q, rgb_d;
  logic           visible, in_box;
  logic [CNT_W:0] hc_w, vc_w;

  assign step = frame_tick_q & ~pause;

  bounce_axis #(.LIM(H_VISIBLE - BOX_W), .SPEED(SPEED), .INIT(INIT_X)) u_axis_x (
    .vgaclk(vgaclk), .rst(rst), .step(step), .pos(pos_x), .bounce(bounce_x)
  );

  bounce_axis #(.LIM(V_VISIBLE - BOX_H), .SPEED(SPEED), .INIT(INIT_Y)) u_axis_y (
    .vgaclk(vgaclk), .rst(rst), .step(step), .pos(pos_y), .bounce(bounce_y)
  );

  // Box compare is one bit wider than the counters so pos+BOX_W never wraps.
  assign hc_w    = {1'b0, hc_in};
  assign vc_w    = {1'b0, vc_in};
  assign visible = (hc_in < CNT_W'(H_VISIBLE)) && (vc_in < CNT_W'(V_VISIBLE));
  assign in_box  = (hc_w >= pos_x) && (hc_w < pos_x + (CNT_W+1)'(BOX_W)) &&
                   (vc_w >= pos_y) && (vc_w < pos_y + (CNT_W+1)'(BOX_H));

  always_comb begin
    frame_tick_d = (hc_in == '0) && (vc_in == CNT_W'(V_VISIBLE));
    color_idx_d  = color_idx_q;
    if (step && (bounce_x || bounce_y)) color_idx_d = color_idx_q + 3'd1;
    rgb_d = 8'h00;
    if (visible) rgb_d = in_box ? palette_color(color_idx_q) : BG_COLOR;
  end

  always_ff @(posedge vgaclk) begin
    if (!rst) begin
      frame_tick_q <= 1'b0;
      color_idx_q  <= '0;
      rgb_q        <= '0;
    end else begin
      frame_tick_q <= frame_tick_d;
      color_idx_q  <= color_idx_d;
      rgb_q        <= rgb_d;
    end
  end

  assign input_red   = rgb_q[7:5];
  assign input_green = rgb_q[4:2];
  assign input_blue  = rgb_q[1:0];
  assign frame_tick  = frame_tick_q;
endmodule

// File: tb/tb_box_pixel_gen.sv
// Directed bench for box_pixel_gen: three instances (default, near right edge, near corner).
module tb_box_pixel_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] hc = '0, vc = '0;
  logic       pause = 1'b0;

  logic [2:0] r0, g0, r1, g1, r2, g2;
  logic [1:0] b0, b1, b2;
  logic       t0, t1, t2;

  int checks = 0;
  int errors = 0;
  int ntick;
  int tick_at_480;

  always #5 clk = ~clk;

  box_pixel_gen dut (
    .vgaclk(clk), .rst(rst), .hc_in(hc), .vc_in(vc), .pause(pause),
    .input_red(r0), .input_green(g0), .input_blue(b0), .frame_tick(t0));

  box_pixel_gen #(.INIT_X(600), .INIT_Y(60)) dut_r (
    .vgaclk(clk), .rst(rst), .hc_in(hc), .vc_in(vc), .pause(pause),
    .input_red(r1), .input_green(g1), .input_blue(b1), .frame_tick(t1));

  box_pixel_gen #(.INIT_X(606), .INIT_Y(446)) dut_c (
    .vgaclk(clk), .rst(rst), .hc_in(hc), .vc_in(vc), .pause(pause),
    .input_red(r2), .input_green(g2), .input_blue(b2), .frame_tick(t2));

  function automatic logic [7:0] rgb_of(input int sel);
    case (sel)
      0:       rgb_of = {r0, g0, b0};
      1:       rgb_of = {r1, g1, b1};
      default: rgb_of = {r2, g2, b2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic px(input int h, input int v);
    @(negedge clk);
    hc = h[9:0];
    vc = v[9:0];
    @(posedge clk);
    #1;
  endtask

  task automatic pxchk(input int sel, input int h, input int v, input logic [7:0] exp, input string tag);
    px(h, v);
    chk(tag, {24'd0, rgb_of(sel)}, {24'd0, exp});
  endtask

  // Probes the box corners and the pixels just outside it.
  task automatic check_box(input int sel, input int x, input int y, input logic [7:0] c, input string tag);
    pxchk(sel, x, y, c, {tag, "_tl"});
    pxchk(sel, x + 31, y + 31, c, {tag, "_br"});
    pxchk(sel, x - 1, y, 8'h02, {tag, "_left"});
    pxchk(sel, x, y - 1, 8'h02, {tag, "_above"});
    pxchk(sel, x + 32, y, (x + 32 < 640) ? 8'h02 : 8'h00, {tag, "_right"});
    pxchk(sel, x, y + 32, (y + 32 < 480) ? 8'h02 : 8'h00, {tag, "_below"});
  endtask

  task automatic do_tick();
    px(0, 480);
    if (t0) ntick++;
    px(1, 480);
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset held for three clocks
    hc = 10'd100;
    vc = 10'd60;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", {24'd0, rgb_of(0)}, 32'h0);
    chk("reset_tick", {31'd0, t0}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Rendering at the reset position
    pxchk(0, 100, 60, 8'hE0, "first_px");
    pxchk(0, 131, 60, 8'hE0, "box_right_col");
    pxchk(0, 132, 60, 8'h02, "bg_right");
    pxchk(0, 100, 92, 8'h02, "bg_below");
    pxchk(0, 700, 100, 8'h00, "hblank");
    pxchk(0, 10, 500, 8'h00, "vblank");
    pxchk(0, 900, 100, 8'h00, "hc_over_total");
    pxchk(0, 100, 530, 8'h00, "vc_over_total");

    // Sweep the lines around the start of vertical blanking
    ntick = 0;
    tick_at_480 = 0;
    for (int v = 478; v < 482; v++) begin
      for (int h = 0; h < 800; h++) begin
        px(h, v);
        if (t0) begin
          ntick++;
          if (h == 0 && v == 480) tick_at_480 = 1;
        end
      end
    end
    chk("tick_count", ntick, 1);
    chk("tick_position", tick_at_480, 1);
    check_box(0, 102, 62, 8'hE0, "moved");

    // Pause across three ticks
    pause = 1'b1;
    ntick = 0;
    repeat (3) do_tick();
    pause = 1'b0;
    chk("pause_ticks", ntick, 3);
    check_box(0, 102, 62, 8'hE0, "paused");

    // Reset in the middle of a line
    pxchk(0, 110, 65, 8'hE0, "pre_midreset");
    @(negedge clk);
    rst = 1'b0;
    hc = 10'd111;
    @(posedge clk);
    #1;
    chk("midreset_rgb", {24'd0, rgb_of(0)}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check_box(0, 100, 60, 8'hE0, "after_midreset");

    // Right-edge bounce
    reset_all();
    repeat (4) do_tick();
    check_box(1, 608, 68, 8'hFC, "right_clamp");
    pxchk(1, 639, 68, 8'hFC, "right_last_col");
    do_tick();
    check_box(1, 606, 70, 8'hFC, "right_return");

    // Corner bounce on both axes in the same frame
    reset_all();
    check_box(2, 606, 446, 8'hE0, "corner_init");
    do_tick();
    check_box(2, 608, 448, 8'hFC, "corner_clamp");
    pxchk(2, 639, 479, 8'hFC, "corner_last_px");
    do_tick();
    check_box(2, 606, 446, 8'hFC, "corner_return");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
